// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: bundle of the handshake, payload and counter signals of
// one pipe_stage_reg instance.
//   slave  modport: used by the register chain (inputs in, outputs out)
//   master modport: used by whatever drives and observes the chain
// Signals:
//   stall, flush, cnt_clr           pipeline/counter control
//   in_valid, in_ctrl, in_data      entry presented to stage 0
//   out_valid, out_ctrl, out_data   contents of the last stage
//   stall_cnt, bubble_cnt           saturating performance counters
interface pipe_stage_reg_if #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              cnt_clr;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport slave (
    input  stall, flush, cnt_clr, in_valid, in_ctrl, in_data,
    output out_valid, out_ctrl, out_data, stall_cnt, bubble_cnt
  );

  modport master (
    output stall, flush, cnt_clr, in_valid, in_ctrl, in_data,
    input  out_valid, out_ctrl, out_data, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline latch chain of DEPTH stages
// carrying a valid bit, a control bundle and a data bundle. Supports stall
// (hold), flush (turn every stage into a bubble) and counts stall cycles and
// bubbles leaving the chain with saturating counters.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (clears all state, data included)
//   bus  pipe_stage_reg_if.slave: stall/flush/cnt_clr, in_* entry,
//        out_* last-stage contents, stall_cnt/bubble_cnt counters
// Edge priority: rst > flush > stall > advance. Outputs come straight from
// the last stage registers.
module pipe_stage_reg #(
  parameter int DATA_W   = 64,
  parameter int CTRL_W   = 4,
  parameter int DEPTH    = 1,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_reg_if.slave  bus
);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be in 1..8");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DEPTH-1:0]  vld_q;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Values each stage loads on an advance edge.
  logic [DEPTH-1:0]  vld_d;
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              advance;

  assign advance = !bus.flush && !bus.stall;

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = bus.in_valid;
    // Control is gated so an invalid entry always becomes a NOP bubble.
    ctrl_d[0] = bus.in_ctrl & {CTRL_W{bus.in_valid}};
    data_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      ctrl_d[i] = ctrl_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (bus.stall && !bus.flush) stall_cnt_d = sat_inc(stall_cnt_q);
      // Counted when the bubble reaches the last stage, not when a flush makes it.
      if (advance && !vld_d[DEPTH-1]) bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q        <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      if (bus.flush) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          ctrl_q[i] <= '0;
          if (CLR_DATA != 0) data_q[i] <= '0;
        end
      end else if (!bus.stall) begin
        vld_q <= vld_d;
        for (int i = 0; i < DEPTH; i++) begin
          ctrl_q[i] <= ctrl_d[i];
          data_q[i] <= data_d[i];
        end
      end
    end
  end

  assign bus.out_valid  = vld_q[DEPTH-1];
  assign bus.out_ctrl   = ctrl_q[DEPTH-1];
  assign bus.out_data   = data_q[DEPTH-1];
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // d1: DEPTH=1, d3: DEPTH=3, d2: DEPTH=2 CLR_DATA=0, ds: DEPTH=1 CNT_W=4
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(4), .CNT_W(16)) if1 ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(4), .CNT_W(16)) if3 ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(4), .CNT_W(16)) if2 ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(4), .CNT_W(4))  ifs ();

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .DEPTH(1), .CLR_DATA(0), .CNT_W(16))
    u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .DEPTH(3), .CLR_DATA(0), .CNT_W(16))
    u_d3 (.clk(clk), .rst(rst), .bus(if3.slave));
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .DEPTH(2), .CLR_DATA(0), .CNT_W(16))
    u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .DEPTH(1), .CLR_DATA(0), .CNT_W(4))
    u_ds (.clk(clk), .rst(rst), .bus(ifs.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if1.stall = 0; if1.flush = 0; if1.cnt_clr = 0; if1.in_valid = 0; if1.in_ctrl = '0; if1.in_data = '0;
    if3.stall = 0; if3.flush = 0; if3.cnt_clr = 0; if3.in_valid = 0; if3.in_ctrl = '0; if3.in_data = '0;
    if2.stall = 0; if2.flush = 0; if2.cnt_clr = 0; if2.in_valid = 0; if2.in_ctrl = '0; if2.in_data = '0;
    ifs.stall = 0; ifs.flush = 0; ifs.cnt_clr = 0; ifs.in_valid = 0; ifs.in_ctrl = '0; ifs.in_data = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    // Load something first so reset has state to clear.
    idle_all();
    if1.in_valid = 1; if1.in_ctrl = 4'hF; if1.in_data = 64'h1111;
    if2.in_valid = 1; if2.in_ctrl = 4'hF; if2.in_data = 64'h2222;
    if2.stall = 0;
    tick(); tick();
    do_reset();
    checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_d1_valid: got %0b want 0", if1.out_valid); end
    checks++; if (if1.out_ctrl !== 4'h0) begin errors++; $display("FAIL rst_d1_ctrl: got %h want 0", if1.out_ctrl); end
    checks++; if (if1.out_data !== 64'h0) begin errors++; $display("FAIL rst_d1_data: got %h want 0", if1.out_data); end
    checks++; if (if2.out_data !== 64'h0) begin errors++; $display("FAIL rst_d2_data: got %h want 0", if2.out_data); end
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL rst_d3_valid: got %0b want 0", if3.out_valid); end
    checks++; if (if1.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d want 0", if1.stall_cnt); end
    checks++; if (if1.bubble_cnt !== 16'd0) begin errors++; $display("FAIL rst_bubble_cnt: got %0d want 0", if1.bubble_cnt); end
  endtask

  task automatic test_advance();
    do_reset();
    if1.in_valid = 1; if1.in_ctrl = 4'b1011; if1.in_data = 64'hDEAD_BEEF_0000_1234;
    tick();
    if1.in_valid = 0; if1.in_ctrl = '0; if1.in_data = '0;
    checks++; if (if1.out_valid !== 1'b1) begin errors++; $display("FAIL adv_valid: got %0b want 1", if1.out_valid); end
    checks++; if (if1.out_ctrl !== 4'b1011) begin errors++; $display("FAIL adv_ctrl: got %b want 1011", if1.out_ctrl); end
    checks++; if (if1.out_data !== 64'hDEAD_BEEF_0000_1234) begin errors++; $display("FAIL adv_data: got %h want deadbeef00001234", if1.out_data); end
    checks++; if (if1.bubble_cnt !== 16'd0) begin errors++; $display("FAIL adv_bubble_cnt: got %0d want 0", if1.bubble_cnt); end
  endtask

  task automatic test_bubble_gating();
    do_reset();
    if1.in_valid = 0; if1.in_ctrl = 4'b1111; if1.in_data = 64'h55;
    tick();
    checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL bub_valid: got %0b want 0", if1.out_valid); end
    checks++; if (if1.out_ctrl !== 4'b0000) begin errors++; $display("FAIL bub_ctrl: got %b want 0000", if1.out_ctrl); end
    checks++; if (if1.out_data !== 64'h55) begin errors++; $display("FAIL bub_data: got %h want 55", if1.out_data); end
    checks++; if (if1.bubble_cnt !== 16'd1) begin errors++; $display("FAIL bub_cnt1: got %0d want 1", if1.bubble_cnt); end
    if1.in_valid = 1; if1.in_ctrl = 4'b0110;
    tick();
    if1.in_valid = 0;
    checks++; if (if1.bubble_cnt !== 16'd1) begin errors++; $display("FAIL bub_cnt_valid: got %0d want 1", if1.bubble_cnt); end
    checks++; if (if1.out_ctrl !== 4'b0110) begin errors++; $display("FAIL bub_ctrl_valid: got %b want 0110", if1.out_ctrl); end
  endtask

  task automatic test_latency();
    do_reset();
    if3.in_valid = 1; if3.in_ctrl = 4'h1; if3.in_data = 64'hA;
    tick();  // edge 1
    if3.in_ctrl = 4'h2; if3.in_data = 64'hB;
    tick();  // edge 2
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %0b want 0", if3.out_valid); end
    if3.in_ctrl = 4'h4; if3.in_data = 64'hC;
    tick();  // edge 3: A out
    if3.in_valid = 0; if3.in_ctrl = '0; if3.in_data = '0;
    checks++; if (if3.out_data !== 64'hA || if3.out_valid !== 1'b1) begin errors++; $display("FAIL lat_A: got %h/%0b want a/1", if3.out_data, if3.out_valid); end
    tick();  // edge 4: B out
    checks++; if (if3.out_data !== 64'hB || if3.out_ctrl !== 4'h2) begin errors++; $display("FAIL lat_B: got %h/%h want b/2", if3.out_data, if3.out_ctrl); end
    tick();  // edge 5: C out
    checks++; if (if3.out_data !== 64'hC || if3.out_ctrl !== 4'h4) begin errors++; $display("FAIL lat_C: got %h/%h want c/4", if3.out_data, if3.out_ctrl); end
    if3.stall = 1;
    tick(); tick();
    if3.stall = 0;
    checks++; if (if3.out_data !== 64'hC || if3.out_valid !== 1'b1) begin errors++; $display("FAIL lat_stall_hold: got %h/%0b want c/1", if3.out_data, if3.out_valid); end
    checks++; if (if3.stall_cnt !== 16'd2) begin errors++; $display("FAIL lat_stall_cnt: got %0d want 2", if3.stall_cnt); end
    checks++; if (if3.bubble_cnt !== 16'd2) begin errors++; $display("FAIL lat_bubble_cnt: got %0d want 2", if3.bubble_cnt); end
    tick();  // bubble behind C reaches the output
    checks++; if (if3.out_valid !== 1'b0 || if3.bubble_cnt !== 16'd3) begin errors++; $display("FAIL lat_after_stall: got %0b/%0d want 0/3", if3.out_valid, if3.bubble_cnt); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    if2.in_valid = 1; if2.in_ctrl = 4'b0101; if2.in_data = 64'hD1;
    tick();
    if2.in_ctrl = 4'b0011; if2.in_data = 64'hD2;
    tick();
    checks++; if (if2.out_valid !== 1'b1 || if2.out_ctrl !== 4'b0101) begin errors++; $display("FAIL fl_pre: got %0b/%b want 1/0101", if2.out_valid, if2.out_ctrl); end
    if2.in_ctrl = 4'b1111; if2.in_data = 64'hEE;
    if2.flush = 1; if2.stall = 1;
    tick();
    if2.flush = 0; if2.stall = 0; if2.in_valid = 0; if2.in_ctrl = '0; if2.in_data = '0;
    checks++; if (if2.out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %0b want 0", if2.out_valid); end
    checks++; if (if2.out_ctrl !== 4'b0000) begin errors++; $display("FAIL fl_ctrl: got %b want 0000", if2.out_ctrl); end
    checks++; if (if2.out_data !== 64'hD1) begin errors++; $display("FAIL fl_data_held: got %h want d1", if2.out_data); end
    checks++; if (if2.stall_cnt !== 16'd0) begin errors++; $display("FAIL fl_stall_cnt: got %0d want 0", if2.stall_cnt); end
    checks++; if (if2.bubble_cnt !== 16'd1) begin errors++; $display("FAIL fl_bubble_nocount: got %0d want 1", if2.bubble_cnt); end
    tick();  // flushed stage 0 (data D2, not the discarded EE) moves out
    checks++; if (if2.out_data !== 64'hD2 || if2.out_valid !== 1'b0 || if2.out_ctrl !== 4'b0) begin errors++; $display("FAIL fl_stage0: got %h/%0b/%b want d2/0/0000", if2.out_data, if2.out_valid, if2.out_ctrl); end
    checks++; if (if2.bubble_cnt !== 16'd2) begin errors++; $display("FAIL fl_bubble_out: got %0d want 2", if2.bubble_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    ifs.stall = 1;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (ifs.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall: got %0d want 15", ifs.stall_cnt); end
    tick();
    checks++; if (ifs.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_hold: got %0d want 15", ifs.stall_cnt); end
    ifs.cnt_clr = 1;
    tick();
    ifs.cnt_clr = 0;
    checks++; if (ifs.stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr: got %0d want 0", ifs.stall_cnt); end
    tick();
    checks++; if (ifs.stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_after_clr: got %0d want 1", ifs.stall_cnt); end
    ifs.stall = 0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (ifs.bubble_cnt !== 4'd15) begin errors++; $display("FAIL sat_bubble: got %0d want 15", ifs.bubble_cnt); end
    checks++; if (ifs.stall_cnt !== 4'd1) begin errors++; $display("FAIL sat_stall_idle: got %0d want 1", ifs.stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    if3.in_valid = 1; if3.in_ctrl = 4'h7; if3.in_data = 64'h77;
    tick();
    if3.in_valid = 0; if3.in_ctrl = '0; if3.in_data = '0;
    tick(); tick();
    if3.stall = 1;
    tick();
    checks++; if (if3.out_valid !== 1'b1 || if3.stall_cnt !== 16'd1) begin errors++; $display("FAIL rms_pre: got %0b/%0d want 1/1", if3.out_valid, if3.stall_cnt); end
    if3.flush = 1;
    rst = 1;
    tick();
    rst = 0; if3.stall = 0; if3.flush = 0;
    checks++; if (if3.out_valid !== 1'b0 || if3.out_ctrl !== 4'h0 || if3.out_data !== 64'h0) begin errors++; $display("FAIL rms_outs: got %0b/%h/%h want 0/0/0", if3.out_valid, if3.out_ctrl, if3.out_data); end
    checks++; if (if3.stall_cnt !== 16'd0 || if3.bubble_cnt !== 16'd0) begin errors++; $display("FAIL rms_cnts: got %0d/%0d want 0/0", if3.stall_cnt, if3.bubble_cnt); end
    if3.in_valid = 1; if3.in_ctrl = 4'h9; if3.in_data = 64'h99;
    tick();
    if3.in_valid = 0; if3.in_ctrl = '0; if3.in_data = '0;
    tick();
    checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL rms_lat2: got %0b want 0", if3.out_valid); end
    tick();
    checks++; if (if3.out_valid !== 1'b1 || if3.out_data !== 64'h99 || if3.out_ctrl !== 4'h9) begin errors++; $display("FAIL rms_lat3: got %0b/%h/%h want 1/99/9", if3.out_valid, if3.out_data, if3.out_ctrl); end
  endtask

  initial begin
    idle_all();
    tick();
    test_reset();
    test_advance();
    test_bubble_gating();
    test_latency();
    test_flush_stall();
    test_saturation();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
